// File: rtl/rle_compressor.sv
// Run-length compressor for a bit stream delivered as WORD_W-bit words.
// Each stream produces one header word (the value of the first bit) followed by
// one code-word per run holding the cumulative bit position at that run's end.
// The final code-word of a stream is flagged with dout_last.
module rle_compressor #(
   parameter int unsigned WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   input  logic              din_last,
   output logic              din_ready,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_last,
   input  logic              dout_ready,
   output logic              error
);

   localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   // StFinal holds the last code-word of a stream until it is accepted.
   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
      StScan,
      StEmit,
      StFinal
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic              last_q, last_d;
   logic              cur_bit_q, cur_bit_d;
   logic [WORD_W:0]   pos_q, pos_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              error_q, error_d;
   logic [WORD_W:0]   pos_inc;

   assign pos_inc = pos_q + (WORD_W + 1)'(1);
   assign error   = error_q;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         buf_q     <= '0;
         last_q    <= 1'b0;
         cur_bit_q <= 1'b0;
         pos_q     <= '0;
         idx_q     <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         last_q    <= last_d;
         cur_bit_q <= cur_bit_d;
         pos_q     <= pos_d;
         idx_q     <= idx_d;
         error_q   <= error_d;
      end
   end

   // Next-state logic and outputs; outputs depend only on registered state so
   // they stay stable while a code-word is stalled.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      last_d     = last_q;
      cur_bit_d  = cur_bit_q;
      pos_d      = pos_q;
      idx_d      = idx_q;
      error_d    = error_q;
      din_ready  = 1'b0;
      dout       = '0;
      dout_valid = 1'b0;
      dout_last  = 1'b0;

      unique case (state_q)
         StIdle: begin
            din_ready = 1'b1;
            if (din_valid) begin
               buf_d     = din;
               last_d    = din_last;
               cur_bit_d = din[0];
               pos_d     = '0;
               idx_d     = '0;
               state_d   = StHdr;
            end
         end
         StHdr: begin
            dout       = WORD_W'(cur_bit_q);
            dout_valid = 1'b1;
            if (dout_ready) begin
               state_d = StScan;
            end
         end
         StLoad: begin
            din_ready = 1'b1;
            if (din_valid) begin
               buf_d   = din;
               last_d  = din_last;
               idx_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (buf_q[idx_q] == cur_bit_q) begin
               pos_d   = pos_inc;
               // Sticky: once the count reaches 2^WORD_W the stream length is lost.
               error_d = error_q | pos_inc[WORD_W];
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = last_q ? StFinal : StLoad;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               // Run ends before bit idx_q; that bit is counted after the emit.
               state_d = StEmit;
            end
         end
         StEmit: begin
            dout       = pos_q[WORD_W-1:0];
            dout_valid = 1'b1;
            if (dout_ready) begin
               cur_bit_d = ~cur_bit_q;
               state_d   = StScan;
            end
         end
         StFinal: begin
            dout       = pos_q[WORD_W-1:0];
            dout_valid = 1'b1;
            dout_last  = 1'b1;
            if (dout_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_rle_compressor.sv
// Self-checking bench for rle_compressor: scenario tasks fill an expected
// queue, a shared driver feeds the stream and captures output transfers, and
// each task compares captured against expected.
module tb_rle_compressor;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
      logic         e;
   } rec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_last;
   logic         din_ready;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_last;
   logic         dout_ready;
   logic         error;

   logic [W-1:0] stim_w[$];
   rec_t         exp_q[$];
   rec_t         rx_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           stall_bad;
   int           n_in;
   bit           timed_out;

   rle_compressor #(.WORD_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_last  (din_last),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_last (dout_last),
      .dout_ready(dout_ready),
      .error     (error)
   );

   always #5 clk = ~clk;

   function automatic void push_exp(input logic [W-1:0] d, input logic l, input logic e);
      rec_t r;
      r.d = d;
      r.l = l;
      r.e = e;
      exp_q.push_back(r);
   endfunction

   // Reference: walk every bit of the stream, emitting at each bit change.
   function automatic void model_build();
      int unsigned pos = 0;
      logic        prev;
      logic        b;
      logic [W-1:0] w;
      exp_q.delete();
      w = stim_w[0];
      prev = w[0];
      push_exp(W'(prev), 1'b0, 1'b0);
      foreach (stim_w[k]) begin
         w = stim_w[k];
         for (int i = 0; i < int'(W); i++) begin
            b = w[i];
            if (b != prev) begin
               push_exp(pos[W-1:0], 1'b0, 1'b0);
               prev = b;
            end
            pos++;
         end
      end
      push_exp(pos[W-1:0], 1'b1, 1'b0);
   endfunction

   // Feeds stim_w (din_valid held high until each word is taken) and records
   // every output transfer. mode: 0 always ready, 1 toggling, 2 random.
   task automatic run_stream(input int mode, input int budget);
      int   wi = 0;
      int   cyc = 0;
      bit   done = 0;
      bit   stalled = 0;
      rec_t held;
      rec_t r;
      rx_q.delete();
      stall_bad = 0;
      n_in = 0;
      timed_out = 0;
      held = '0;
      @(posedge clk);
      #1;
      while (1) begin
         din_valid = (wi < stim_w.size());
         din       = (wi < stim_w.size()) ? stim_w[wi] : '0;
         din_last  = (wi == stim_w.size() - 1);
         case (mode)
            1:       dout_ready = cyc[0];
            2:       dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = 1'b1;
         endcase
         @(negedge clk);
         if (stalled && !(dout_valid === 1'b1 && dout === held.d && dout_last === held.l))
            stall_bad++;
         if (din_valid && din_ready) begin
            wi++;
            n_in++;
         end
         r.d = dout;
         r.l = dout_last;
         r.e = error;
         if (dout_valid && dout_ready) begin
            rx_q.push_back(r);
            if (dout_last) done = 1;
         end
         stalled = dout_valid && !dout_ready;
         held = r;
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
         if (cyc > budget) begin
            timed_out = 1;
            break;
         end
      end
      din_valid  = 1'b0;
      din_last   = 1'b0;
      dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      din_last = 1'b0;
      din = '0;
      dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid);
      end
      n_checks++;
      if (dout !== '0) begin
         n_fail++; $display("FAIL reset_dout: got %h want 0000", dout);
      end
      n_checks++;
      if (dout_last !== 1'b0) begin
         n_fail++; $display("FAIL reset_dout_last: got %b want 0", dout_last);
      end
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++; $display("FAIL reset_error: got %b want 0", error);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (din_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_din_ready: got %b want 1", din_ready);
      end
   endtask

   task automatic test_single_word();
      // 0x00FF: run of ones ends at 8, stream ends at 16
      stim_w = '{16'h00FF};
      exp_q.delete();
      push_exp(16'h0001, 1'b0, 1'b0);
      push_exp(16'h0008, 1'b0, 1'b0);
      push_exp(16'h0010, 1'b1, 1'b0);
      run_stream(0, 200);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL single_count: got %0d words (timeout %0d) want %0d",
                            rx_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL single_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
      // Constant word: header plus final only
      stim_w = '{16'h0000};
      exp_q.delete();
      push_exp(16'h0000, 1'b0, 1'b0);
      push_exp(16'h0010, 1'b1, 1'b0);
      run_stream(0, 200);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL const_count: got %0d words want %0d", rx_q.size(),
                            exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL const_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
   endtask

   task automatic test_two_word();
      // Run boundary exactly on the word boundary
      stim_w = '{16'hFFFF, 16'h0000};
      exp_q.delete();
      push_exp(16'h0001, 1'b0, 1'b0);
      push_exp(16'h0010, 1'b0, 1'b0);
      push_exp(16'h0020, 1'b1, 1'b0);
      run_stream(0, 300);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL two_word_count: got %0d words want %0d", rx_q.size(),
                            exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL two_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
   endtask

   task automatic test_backpressure();
      stim_w = '{16'hAAAA};
      exp_q.delete();
      push_exp(16'h0000, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) push_exp(W'(i), 1'b0, 1'b0);
      push_exp(16'h0010, 1'b1, 1'b0);
      run_stream(1, 500);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL bp_count: got %0d words want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL bp_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
      n_checks++;
      if (stall_bad != 0) begin
         n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_bad);
      end
   endtask

   task automatic test_reset_mid();
      bit   hit = 0;
      bit   acc;
      rec_t got[$];
      din = 16'h0F0F;
      din_last = 1'b1;
      din_valid = 1'b1;
      dout_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         @(negedge clk);
         acc = din_valid && din_ready;
         if (dout_valid && dout_ready) begin
            if (dout == 16'h0008) begin
               hit = 1;
               rst = 1'b1;
            end else begin
               got.push_back('{d: dout, l: dout_last, e: error});
            end
         end
         @(posedge clk);
         #1;
         if (acc) din_valid = 1'b0;
      end
      n_checks++;
      if (!hit) begin
         n_fail++; $display("FAIL midrst_reach: got no 0008 emit want one within 100 cycles");
      end
      n_checks++;
      if (got.size() != 2 || got[0].d !== 16'h0001 || got[1].d !== 16'h0004) begin
         n_fail++; $display("FAIL midrst_prefix: got %0d words want 0001,0004", got.size());
      end
      n_checks++;
      if (dout_valid !== 1'b0 || error !== 1'b0) begin
         n_fail++; $display("FAIL midrst_state: got valid %b error %b want 0 0",
                            dout_valid, error);
      end
      rst = 1'b0;
      din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_quiet: got dout_valid %b want 0", dout_valid);
      end
      stim_w = '{16'h0001};
      exp_q.delete();
      push_exp(16'h0001, 1'b0, 1'b0);
      push_exp(16'h0001, 1'b0, 1'b0);
      push_exp(16'h0010, 1'b1, 1'b0);
      run_stream(0, 200);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL midrst_count: got %0d words want %0d", rx_q.size(),
                            exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL midrst_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_w = '{16'h1234, 16'h8001};
      model_build();
      run_stream(0, 400);
      n_checks++;
      if (n_in != 2) begin
         n_fail++; $display("FAIL b2b_consumed: got %0d words taken want 2", n_in);
      end
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d words want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
            n_fail++; $display("FAIL b2b_word[%0d]: got %h/%b want %h/%b", i,
                               rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int s = 0; s < 4; s++) begin
         stim_w.delete();
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) stim_w.push_back(W'($urandom));
         model_build();
         run_stream(2, 2000);
         n_checks++;
         if (timed_out || rx_q.size() != exp_q.size() || n_in != n) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d words/%0d in want %0d/%0d", s,
                               rx_q.size(), n_in, exp_q.size(), n);
         end
         for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i].d !== exp_q[i].d || rx_q[i].l !== exp_q[i].l) begin
               n_fail++; $display("FAIL rand%0d_word[%0d]: got %h/%b want %h/%b", s, i,
                                  rx_q[i].d, rx_q[i].l, exp_q[i].d, exp_q[i].l);
            end
         end
         n_checks++;
         if (stall_bad != 0) begin
            n_fail++; $display("FAIL rand%0d_stable: got %0d unstable cycles want 0", s,
                               stall_bad);
         end
      end
   endtask

   task automatic test_overflow();
      // 65536 zero bits wrap the count to 0 and raise error
      stim_w.delete();
      for (int k = 0; k < 4096; k++) stim_w.push_back(16'h0000);
      stim_w.push_back(16'hFFFF);
      exp_q.delete();
      push_exp(16'h0000, 1'b0, 1'b0);
      push_exp(16'h0000, 1'b0, 1'b1);
      push_exp(16'h0010, 1'b1, 1'b1);
      run_stream(0, 80000);
      n_checks++;
      if (timed_out || rx_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL ovf_count: got %0d words want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL ovf_word[%0d]: got %h/%b/%b want %h/%b/%b", i,
                               rx_q[i].d, rx_q[i].l, rx_q[i].e, exp_q[i].d, exp_q[i].l,
                               exp_q[i].e);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (error !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sticky: got error %b want 1", error);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got error %b want 0", error);
      end
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      din_valid = 1'b0;
      din_last = 1'b0;
      dout_ready = 1'b0;
      test_reset();
      test_single_word();
      test_two_word();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
